// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns one LB/LH/LW/LBU/LHU/SB/SH/SW into a single word-aligned
// valid/ready memory transaction, returning extended load data plus misalignment/fault status.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ReadData,
  output logic        Misaligned,
  output logic        Fault,
  output logic        MemReq,
  input  logic        MemReady,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemWStrb,
  output logic [31:0] MemWData,
  input  logic        MemRValid,
  input  logic [31:0] MemRData
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_we, r_fault, r_misal;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata, r_ld_word;
  logic [7:0]  r_cnt;
  logic        r_done, r_misal_o, r_fault_o;
  logic [31:0] r_rdata;

  logic        w_illegal, w_misal, w_limit, w_abort, w_in_req;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_ext, w_wdata_rep;
  logic [3:0]  w_strb;

  // Illegal encodings outrank misalignment, so misalignment is only meaningful for legal ops.
  assign w_illegal = MemWrite ? !(Funct3 inside {3'b000, 3'b001, 3'b010})
                              : ((Funct3 == 3'b011) || (Funct3[2:1] == 2'b11));
  assign w_misal   = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                     ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));

  // The counter holds (cycles spent - 1), so the limit cycle is the TIMEOUT_CYCLES-th one.
  assign w_limit = (r_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign w_abort = w_limit && (((r_state == S_REQ) && !MemReady) ||
                               ((r_state == S_WAIT_R) && !MemRValid));

  assign w_byte = 8'(MemRData >> {r_addr[1:0], 3'b000});
  assign w_half = r_addr[1] ? MemRData[31:16] : MemRData[15:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_ld_ext = MemRData;
    case (r_f3)
      3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_ext = {24'h0, w_byte};
      3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_ext = {16'h0, w_half};
      default: w_ld_ext = MemRData;
    endcase
  end

  always_comb begin
    w_strb      = 4'b1111;
    w_wdata_rep = r_wdata;
    case (r_f3[1:0])
      2'b00: begin
        w_strb      = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_strb      = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (Start) w_next = (w_illegal || w_misal) ? S_DONE : S_REQ;
      S_REQ:    if (MemReady) w_next = r_we ? S_DONE : S_WAIT_R;
                else if (w_abort) w_next = S_DONE;
      S_WAIT_R: if (MemRValid || w_abort) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_f3      <= 3'b000;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_fault   <= 1'b0;
      r_misal   <= 1'b0;
      r_ld_word <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_misal_o <= 1'b0;
      r_fault_o <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_next;
      r_done    <= 1'b0;
      r_misal_o <= 1'b0;
      r_fault_o <= 1'b0;
      case (r_state)
        S_IDLE: if (Start) begin
          r_we    <= MemWrite;
          r_f3    <= Funct3;
          r_addr  <= ALUResult;
          r_wdata <= WriteData;
          r_fault <= w_illegal;
          r_misal <= !w_illegal && w_misal;
          r_cnt   <= '0;
        end
        S_REQ, S_WAIT_R: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_abort) r_fault <= 1'b1;
          if ((r_state == S_WAIT_R) && MemRValid) r_ld_word <= w_ld_ext;
        end
        S_DONE: begin
          r_done    <= 1'b1;
          r_misal_o <= r_misal;
          r_fault_o <= r_fault;
          // Loads that fail clear the result; stores and misaligned ops keep the old value.
          if (!r_we && !r_misal) r_rdata <= r_fault ? '0 : r_ld_word;
        end
        default: ;
      endcase
    end
  end

  assign w_in_req   = (r_state == S_REQ);
  assign Busy       = (r_state != S_IDLE);
  assign Done       = r_done;
  assign Misaligned = r_misal_o;
  assign Fault      = r_fault_o;
  assign ReadData   = r_rdata;
  assign MemReq     = w_in_req;
  assign MemWE      = w_in_req && r_we;
  assign MemAddr    = w_in_req ? {r_addr[31:2], 2'b00} : '0;
  assign MemWStrb   = (w_in_req && r_we) ? w_strb : '0;
  assign MemWData   = (w_in_req && r_we) ? w_wdata_rep : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT_CYCLES=4; cycle 1 is the first cycle after the
// edge that samples Start, and every expected value below is hand-derived.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] alu_result = '0, write_data = '0;
  logic        busy, done, misaligned, fault, mem_req, mem_we;
  logic [31:0] read_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  int          res_done_cyc;
  logic        res_mis, res_flt, res_saw_req, res_we;
  logic [31:0] res_rd, res_addr, res_wdata;
  logic [3:0]  res_strb;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .Start(start), .MemWrite(mem_write), .Funct3(funct3),
    .ALUResult(alu_result), .WriteData(write_data), .Busy(busy), .Done(done),
    .ReadData(read_data), .Misaligned(misaligned), .Fault(fault), .MemReq(mem_req),
    .MemReady(mem_ready), .MemWE(mem_we), .MemAddr(mem_addr), .MemWStrb(mem_wstrb),
    .MemWData(mem_wdata), .MemRValid(mem_rvalid), .MemRData(mem_rdata)
  );

  // Issues one op; MemReady is high only in cycle rdy_cyc, MemRValid only in rv_cyc (-1 = never).
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int rdy_cyc,
                        input int rv_cyc);
    res_done_cyc = -1; res_saw_req = 1'b0; res_mis = 1'b0; res_flt = 1'b0; res_rd = '0;
    res_we = 1'b0; res_addr = '0; res_wdata = '0; res_strb = '0;
    @(negedge clk);
    mem_write = we; funct3 = f3; alu_result = addr; write_data = wd; mem_rdata = rd;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc < 30; cyc++) begin
      @(negedge clk);
      if (done) begin
        res_done_cyc = cyc; res_mis = misaligned; res_flt = fault; res_rd = read_data;
        break;
      end
      if (mem_req && !res_saw_req) begin
        res_saw_req = 1'b1; res_we = mem_we; res_addr = mem_addr;
        res_strb = mem_wstrb; res_wdata = mem_wdata;
      end
      mem_ready  = (cyc == rdy_cyc);
      mem_rvalid = (cyc == rv_cyc);
      @(posedge clk);
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, misaligned, fault, mem_req, mem_we} !== 6'b0 || read_data !== 32'h0 ||
        mem_addr !== 32'h0 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b mis=%b flt=%b req=%b we=%b rd=%h addr=%h strb=%h wd=%h, all required 0",
               busy, done, misaligned, fault, mem_req, mem_we, read_data, mem_addr, mem_wstrb, mem_wdata);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
    logic [31:0] adr [5] = '{32'h1003, 32'h0001, 32'h2002, 32'h2002, 32'h0100};
    logic [31:0] dat [5] = '{32'h80FF_1234, 32'h80FF_1234, 32'hBEEF_0000, 32'hBEEF_0000, 32'hDEAD_BEEF};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0012, 32'h0000_BEEF, 32'hFFFF_BEEF, 32'hDEAD_BEEF};
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, f3[i], adr[i], 32'h0, dat[i], 1, 2);
      checks++;
      if (res_done_cyc !== 4 || res_mis !== 1'b0 || res_flt !== 1'b0) begin
        failures++;
        $display("FAIL load%0d_timing: done_cyc=%0d mis=%b flt=%b, required 4/0/0", i, res_done_cyc, res_mis, res_flt);
      end
      checks++;
      if (res_rd !== exp[i]) begin
        failures++;
        $display("FAIL load%0d_data: got %h required %h", i, res_rd, exp[i]);
      end
      checks++;
      if (res_addr !== {adr[i][31:2], 2'b00} || res_we !== 1'b0 || res_strb !== 4'h0) begin
        failures++;
        $display("FAIL load%0d_req: addr=%h we=%b strb=%h required %h/0/0", i, res_addr, res_we, res_strb, {adr[i][31:2], 2'b00});
      end
    end
  endtask

  task automatic test_stores();
    run_op(1'b1, 3'b000, 32'h11, 32'h0000_00AB, 32'h0, 1, -1);
    checks++;
    if (res_addr !== 32'h10 || res_strb !== 4'b0010 || res_wdata !== 32'hABAB_ABAB || res_we !== 1'b1) begin
      failures++;
      $display("FAIL sb_req: addr=%h strb=%b wd=%h we=%b required 10/0010/ababab ab/1", res_addr, res_strb, res_wdata, res_we);
    end
    checks++;
    if (res_done_cyc !== 3 || res_rd !== 32'hDEAD_BEEF || res_flt !== 1'b0) begin
      failures++;
      $display("FAIL sb_done: done_cyc=%0d rd=%h flt=%b required 3/deadbeef/0", res_done_cyc, res_rd, res_flt);
    end
    run_op(1'b1, 3'b001, 32'h22, 32'h1234_CAFE, 32'h0, 1, -1);
    checks++;
    if (res_addr !== 32'h20 || res_strb !== 4'b1100 || res_wdata !== 32'hCAFE_CAFE || res_done_cyc !== 3) begin
      failures++;
      $display("FAIL sh_req: addr=%h strb=%b wd=%h done_cyc=%0d required 20/1100/cafecafe/3", res_addr, res_strb, res_wdata, res_done_cyc);
    end
  endtask

  task automatic test_misaligned_fault();
    run_op(1'b1, 3'b010, 32'h6, 32'h1, 32'h0, 1, -1);
    checks++;
    if (res_done_cyc !== 2 || res_mis !== 1'b1 || res_flt !== 1'b0 || res_saw_req !== 1'b0 || res_rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL sw_misaligned: cyc=%0d mis=%b flt=%b req=%b rd=%h required 2/1/0/0/deadbeef",
               res_done_cyc, res_mis, res_flt, res_saw_req, res_rd);
    end
    run_op(1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 1, 2);
    checks++;
    if (res_done_cyc !== 2 || res_mis !== 1'b1 || res_saw_req !== 1'b0 || res_rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL lh_misaligned: cyc=%0d mis=%b req=%b rd=%h required 2/1/0/deadbeef", res_done_cyc, res_mis, res_saw_req, res_rd);
    end
    run_op(1'b0, 3'b011, 32'h8, 32'h0, 32'h0, 1, 2);
    checks++;
    if (res_done_cyc !== 2 || res_flt !== 1'b1 || res_mis !== 1'b0 || res_saw_req !== 1'b0 || res_rd !== 32'h0) begin
      failures++;
      $display("FAIL load_illegal: cyc=%0d flt=%b mis=%b req=%b rd=%h required 2/1/0/0/0", res_done_cyc, res_flt, res_mis, res_saw_req, res_rd);
    end
    run_op(1'b1, 3'b100, 32'h1, 32'h0, 32'h0, 1, -1);
    checks++;
    if (res_done_cyc !== 2 || res_flt !== 1'b1 || res_mis !== 1'b0 || res_saw_req !== 1'b0) begin
      failures++;
      $display("FAIL store_illegal_priority: cyc=%0d flt=%b mis=%b req=%b required 2/1/0/0", res_done_cyc, res_flt, res_mis, res_saw_req);
    end
  endtask

  task automatic test_timeout();
    run_op(1'b0, 3'b010, 32'h40, 32'h0, 32'h55AA_55AA, 1, 4);
    checks++;
    if (res_done_cyc !== 6 || res_flt !== 1'b0 || res_rd !== 32'h55AA_55AA) begin
      failures++;
      $display("FAIL rvalid_at_limit: cyc=%0d flt=%b rd=%h required 6/0/55aa55aa", res_done_cyc, res_flt, res_rd);
    end
    run_op(1'b0, 3'b010, 32'h44, 32'h0, 32'h1111_1111, -1, -1);
    checks++;
    if (res_done_cyc !== 6 || res_flt !== 1'b1 || res_rd !== 32'h0 || res_saw_req !== 1'b1) begin
      failures++;
      $display("FAIL lw_timeout: cyc=%0d flt=%b rd=%h req=%b required 6/1/0/1", res_done_cyc, res_flt, res_rd, res_saw_req);
    end
    run_op(1'b1, 3'b010, 32'h48, 32'h7, 32'h0, 4, -1);
    checks++;
    if (res_done_cyc !== 6 || res_flt !== 1'b0) begin
      failures++;
      $display("FAIL ready_at_limit: cyc=%0d flt=%b required 6/0", res_done_cyc, res_flt);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mem_write = 1'b1; funct3 = 3'b010; alu_result = 32'h80; write_data = 32'h1; start = 1'b1;
    @(posedge clk);
    #1 mem_write = 1'b0; alu_result = 32'h200;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80) begin
      failures++;
      $display("FAIL busy_start_ignored: req=%b we=%b addr=%h required 1/1/80", mem_req, mem_we, mem_addr);
    end
    mem_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_state: busy=%b done=%b req=%b required 1/0/0", busy, done, mem_req);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_pulse: done=%b busy=%b required 1/0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_single_pulse: done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    @(negedge clk);
    mem_write = 1'b0; funct3 = 3'b010; alu_result = 32'h300; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_req: req=%b busy=%b required 0/0", mem_req, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk); mem_ready = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_wait_r: req=%b busy=%b required 0/0", mem_req, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done: activity=%b required 0", saw_done);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned_fault();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
